// File: rtl/jk_ms_bank.sv
`default_nettype none
// ============================================================================
// Module      : jk_ms_bank
// Description : Parametrised master-slave JK register bank. WIDTH JK cells
//               share a master stage; the slave stage presents the master
//               value one clock later. Supports per-bit JK operation,
//               parallel load, up/down counting (wrap or saturate) and
//               serial shift-left.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_ms_bank #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   RST_VAL  = '0,
    parameter bit                 SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             so,
    output logic             tc
);

    localparam logic [1:0]       c_MODE_JK = 2'b00;
    localparam logic [1:0]       c_MODE_UP = 2'b01;
    localparam logic [1:0]       c_MODE_DN = 2'b10;
    localparam logic [1:0]       c_MODE_SH = 2'b11;
    localparam logic [WIDTH-1:0] c_ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO    = '0;
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_jk_next;
    logic [WIDTH-1:0] w_m_next;

    // Per-cell JK characteristic equation: Q+ = J.~Q | ~K.Q
    // (00 hold, 01 clear, 10 set, 11 toggle), always evaluated on the master.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_jk
            assign w_jk_next[i] = (j[i] & ~r_m[i]) | (~k[i] & r_m[i]);
        end
    endgenerate

    // Master next-state: load beats enable; with en low the master holds.
    always_comb begin
        w_m_next = r_m;
        if (load) begin
            w_m_next = d;
        end else if (en) begin
            case (mode)
                c_MODE_JK: w_m_next = w_jk_next;
                c_MODE_UP: begin
                    if (SATURATE && (r_m == c_ONES)) w_m_next = r_m;
                    else                             w_m_next = r_m + c_ONE;
                end
                c_MODE_DN: begin
                    if (SATURATE && (r_m == c_ZERO)) w_m_next = r_m;
                    else                             w_m_next = r_m - c_ONE;
                end
                c_MODE_SH: w_m_next = {r_m[WIDTH-2:0], j[0]};
                default:   w_m_next = r_m;
            endcase
        end
    end

    // Master and slave registers; the slave copies the master every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= RST_VAL;
            r_q <= RST_VAL;
        end else begin
            r_m <= w_m_next;
            r_q <= r_m;
        end
    end

    assign q  = r_q;
    assign qb = ~r_q;
    assign so = r_q[WIDTH-1];
    // Terminal count looks at the slave and the live mode input.
    assign tc = ((mode == c_MODE_UP) && (r_q == c_ONES)) ||
                ((mode == c_MODE_DN) && (r_q == c_ZERO));

endmodule
`default_nettype wire

// File: doc/jk_ms_bank.md
# jk_ms_bank

Parametrised master-slave JK register bank: WIDTH independent JK cells with a shared master stage and a slave stage that presents the master value one clock later. Besides per-bit JK operation it has parallel load, binary up/down counting with optional saturation, and serial shift. It is the general-purpose successor to the single-bit master-slave JK cell, and serves as a counter, shift register or flag bank in the day-to-day blocks.

## Interface
- WIDTH, 8, number of JK cells (≥2)
- RST_VAL, 0, reset value of master and slave registers (WIDTH bits)
- SATURATE, 0, 1 = counter modes stop at terminal value; 0 = wrap

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  master update enable
- mode  input  2  00 JK, 01 count up, 10 count down, 11 shift left
- j  input  WIDTH  per-bit J (mode 00); j[0] is serial-in in mode 11
- k  input  WIDTH  per-bit K (mode 00); ignored otherwise
- load  input  1  parallel load of d into master (overrides mode)
- d  input  WIDTH  parallel load data
- q  output  WIDTH  slave register
- qb  output  WIDTH  ~q, combinational
- so  output  1  serial out = q[WIDTH-1]
- tc  output  1  terminal count flag, combinational from q and mode

## Operation
- Two registers: master m[WIDTH-1:0] and slave q[WIDTH-1:0]. Next-state logic reads m, never q.
- Slave: every cycle with rst=0, q <= m, regardless of en.
- Master priority on each rising edge: rst > load > (en=0 hold) > mode operation.
- rst=1: m <= RST_VAL, q <= RST_VAL. load, en and mode are ignored that cycle.
- load=1 (rst=0): m <= d, independent of en.
- en=1, load=0:
  - mode 00, per bit i: {j,k}=00 hold, 01 clear, 10 set, 11 toggle (m[i] <= ~m[i]).
  - mode 01: m <= m + 1 mod 2^WIDTH. If SATURATE=1 and m = all-ones, hold.
  - mode 10: m <= m − 1 mod 2^WIDTH. If SATURATE=1 and m = 0, hold.
  - mode 11: m <= {m[WIDTH-2:0], j[0]}.
- tc = 1 when (mode=01 and q = all-ones) or (mode=10 and q = 0); otherwise 0. tc uses the live mode input.
- A mode change takes effect on the next enabled edge. No state is flushed. The counter continues from the current m.

## Timing
- Reset state: m = q = RST_VAL, qb = ~RST_VAL, so = RST_VAL[WIDTH-1]. tc follows the tc rule on RST_VAL and mode, so with RST_VAL=0 and mode=10, tc=1.
- Latency: an input sampled at edge N updates m at N and is visible on q after edge N+1, i.e. 2 edges from input to q.
- en=0: m holds and q converges to m after one edge, so the slave pipeline drains.
- Wrap (SATURATE=0): up from all-ones gives 0, and down from 0 gives all-ones. tc is high for exactly one cycle per wrap when counting continuously.
- Saturate: m stays at the terminal value and tc stays high while the mode holds.
- Reset mid-count: the edge with rst=1 forces both stages. The first post-reset increment appears on q two edges after rst deasserts.
- Simultaneous load and en: load wins and the count or shift is lost for that edge.

## Test plan
- WIDTH=8, RST_VAL=8'hA5: hold rst 2 cycles → q=8'hA5, qb=8'h5A, so=1. Release with en=0 → q remains 8'hA5.
- Mode 00, from m=q=0: apply j=8'hF0, k=8'h0F for one enabled edge → q=8'hF0 one edge later. Then j=k=8'hFF → q=8'h0F. Then j=k=0 → q holds 8'h0F.
- Mode 01, SATURATE=0: load d=8'hFD, then en=1 for 4 edges → q sequence FD, FE, FF, 00, 01 (one edge behind m). tc=1 only while q=FF.
- Mode 10, SATURATE=1: load 8'h02, then en=1 for 5 edges → q reaches 00 and stays. tc stays 1 from the first cycle q=00.
- Mode 11: load 8'h81, then en=1 with j[0]=1,0,1 → q = 03, 06, 0D on successive cycles after the pipeline edge. so = 1, 0, 0, 0.
- Priority: during counting, assert load=1 (d=8'h40) and rst=1 in the same cycle → q=RST_VAL. Next cycle load alone → q=8'h40 after 2 edges. Deassert en mid-count → q freezes one edge after m.
